seq_divider: RTL and testbench
==============================

Name: seq_divider

Overview:
Iterative unsigned restoring divider. It is the inverse-operation companion to the Wallace-tree multiplier datapath. Each operand pair is accepted through a start/busy/done handshake and resolved one quotient bit per clock. Results are held stable until the next accepted start, so it serves as the divide unit beside the multiplier in the arithmetic core.

Parameters:
WIDTH, 8, bit width of dividend, divisor, quotient and remainder (WIDTH >= 2)

Ports:
clk  input  1  rising-edge clock, the single clock
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE
dividend  input  WIDTH  unsigned dividend; sampled on accepted start
divisor  input  WIDTH  unsigned divisor; sampled on accepted start
busy  output  1  high while state is RUN or DONE
done  output  1  one-cycle pulse; quotient/remainder/dz valid in this cycle and held afterwards
quotient  output  WIDTH  unsigned quotient
remainder  output  WIDTH  unsigned remainder
dz  output  1  divide-by-zero flag for the last completed operation

Behaviour:
- Reset: a rst sampled high on any edge forces state IDLE and clears the iteration count. It also sets busy=0, done=0, quotient=0, remainder=0 and dz=0. This overrides start and any operation in flight; no done pulse is emitted for an aborted operation.
- States are IDLE, RUN and DONE.
- IDLE, start=1, divisor!=0:
  - Latch operands: partial remainder R (WIDTH+1 bits) = 0, shift register Q = dividend, D = divisor.
  - Set count = 0, go to RUN.
  - quotient, remainder and dz keep their previous values until DONE.
- IDLE, start=1, divisor==0:
  - Go directly to DONE with quotient = all ones, remainder = dividend, dz = 1.
- IDLE, start=0: stay in IDLE.
- RUN, per cycle:
  - T = {R[WIDTH-1:0], Q[WIDTH-1]} - {1'b0, D}.
  - If T is non-negative (borrow clear): R = T, and Q shifts left with 1 as the new LSB.
  - Otherwise (restore): R = {R[WIDTH-1:0], Q[WIDTH-1]}, and Q shifts left with 0 as the new LSB.
  - count increments.
  - After the iteration where count reaches WIDTH-1 completes, go to DONE and load quotient = Q (post-iteration) and remainder = R[WIDTH-1:0]. Set dz = 0.
- DONE: done=1 for exactly one cycle, then go to IDLE. busy falls in the same edge that leaves DONE.
- Latency: start is high in cycle 0.
  - Normal operation: done is high in cycle WIDTH+1.
  - Divide-by-zero: done is high in cycle 1.
  - A new start is accepted at the earliest in the cycle after done, i.e. throughput is one op per WIDTH+2 cycles.
- Start handling:
  - start while busy=1 (RUN or DONE) is ignored and has no effect on operands or state.
  - start held continuously high launches a new operation on each return to IDLE.
- Invariants:
  - Operand inputs may change freely after the accepting edge.
  - quotient*divisor + remainder == dividend and remainder < divisor for every non-zero divisor.
  - No signed interpretation anywhere.

Test Plan:
- Reset, then start with dividend=100, divisor=7 -> busy=1 from cycle 1; done pulses in cycle 9; quotient=14, remainder=2, dz=0. Outputs hold 14/2 for 20 idle cycles.
- dividend=200, divisor=0 -> done in cycle 1 with quotient=255, remainder=200, dz=1. A following 50/5 gives quotient=10, remainder=0, dz=0.
- Boundary operands: 255/1 -> 255 r 0. 5/9 -> 0 r 5. 0/3 -> 0 r 0. 255/255 -> 1 r 0. 254/255 -> 0 r 254.
- During a 100/7 op, pulse start with 9/3 in cycles 3 and 9 (DONE) -> both ignored; result is still 14 r 2 and busy drops in cycle 10. start held high thereafter -> next op accepted in cycle 10.
- rst asserted in cycle 5 of a 100/7 op -> next cycle all outputs are 0 and the state is IDLE, with no done pulse. A following 77/10 gives 7 r 7.
- Random sweep of 2000 operand pairs, including zero divisors -> the invariant holds, every done is exactly one cycle wide, and latency is WIDTH+1 (or 1 for a zero divisor).

Source files
------------

// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider: one quotient bit per clock, start/busy/done
// handshake, results held until the next accepted operation completes.
module seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             dz
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   count;
    logic [WIDTH-1:0] r, q, d;

    logic [WIDTH:0]   shifted, trial;
    logic [WIDTH-1:0] r_nxt, q_nxt;
    logic             accept, accept_zero, last;

    assign accept      = (state == IDLE) && start && (divisor != '0);
    assign accept_zero = (state == IDLE) && start && (divisor == '0);
    assign last        = (count == CW'(WIDTH - 1));

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // The partial remainder stays below the divisor, so its top bit is always
    // zero and WIDTH bits suffice; the trial difference keeps the borrow bit.
    always_comb begin
        shifted = {r, q[WIDTH-1]};
        trial   = shifted - {1'b0, d};
        r_nxt   = shifted[WIDTH-1:0];
        q_nxt   = {q[WIDTH-2:0], 1'b0};
        if (!trial[WIDTH]) begin
            r_nxt = trial[WIDTH-1:0];
            q_nxt = {q[WIDTH-2:0], 1'b1};
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept)           state_nxt = RUN;
                else if (accept_zero) state_nxt = DONE;
            end
            RUN:     if (last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count     <= '0;
            quotient  <= '0;
            remainder <= '0;
            dz        <= 1'b0;
        end else if (accept) begin
            count <= '0;
        end else if (accept_zero) begin
            quotient  <= '1;
            remainder <= dividend;
            dz        <= 1'b1;
        end else if (state == RUN) begin
            count <= count + CW'(1);
            if (last) begin
                quotient  <= q_nxt;
                remainder <= r_nxt;
                dz        <= 1'b0;
            end
        end
    end

    // Working registers carry no reset; they are reloaded on every accepted start.
    always_ff @(posedge clk) begin
        if (accept) begin
            r <= '0;
            q <= dividend;
            d <= divisor;
        end else if (state == RUN) begin
            r <= r_nxt;
            q <= q_nxt;
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Directed and randomized checks of seq_divider against plain integer division.
module tb_seq_divider;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] dividend = '0;
    logic [7:0] divisor = '0;
    logic       busy, done, dz;
    logic [7:0] quotient, remainder;

    int checks = 0;
    int failures = 0;

    seq_divider #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .quotient(quotient), .remainder(remainder), .dz(dz)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Launch one op, wait for done, compare with integer division.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input string tag);
        int lat;
        int exp_q, exp_r, exp_lat;
        start = 1'b1; dividend = a; divisor = b;
        tick();
        start = 1'b0; dividend = 8'($urandom); divisor = 8'($urandom);
        chk({tag, ".busy1"}, busy, 1);
        lat = 1;
        while (done !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        exp_lat = (b == 0) ? 1 : 9;
        exp_q   = (b == 0) ? 255 : int'(a) / int'(b);
        exp_r   = (b == 0) ? int'(a) : int'(a) % int'(b);
        chk({tag, ".latency"}, lat, exp_lat);
        chk({tag, ".quotient"}, quotient, exp_q);
        chk({tag, ".remainder"}, remainder, exp_r);
        chk({tag, ".dz"}, dz, (b == 0));
        if (b != 0) begin
            chk({tag, ".identity"}, int'(quotient) * int'(b) + int'(remainder), int'(a));
            chk({tag, ".rem_lt_div"}, (remainder < b), 1);
        end
        tick();
        chk({tag, ".done_width"}, done, 0);
        chk({tag, ".busy_after"}, busy, 0);
    endtask

    initial begin
        int bad;
        logic [7:0] ra, rb;

        repeat (3) tick();
        chk("reset.busy", busy, 0);
        chk("reset.done", done, 0);
        chk("reset.quotient", quotient, 0);
        chk("reset.remainder", remainder, 0);
        chk("reset.dz", dz, 0);
        rst = 1'b0;
        tick();

        do_op(8'd100, 8'd7, "op100_7");
        bad = 0;
        repeat (20) begin
            tick();
            if (quotient !== 8'd14 || remainder !== 8'd2 || done !== 1'b0) bad++;
        end
        chk("hold.idle20", bad, 0);

        do_op(8'd200, 8'd0, "dz200");
        do_op(8'd50, 8'd5, "op50_5");
        do_op(8'd255, 8'd1, "op255_1");
        do_op(8'd5, 8'd9, "op5_9");
        do_op(8'd0, 8'd3, "op0_3");
        do_op(8'd255, 8'd255, "op255_255");
        do_op(8'd254, 8'd255, "op254_255");

        // Starts while busy are ignored; held start relaunches on return to IDLE.
        start = 1'b1; dividend = 8'd100; divisor = 8'd7;
        tick();
        start = 1'b0;
        tick();
        tick();
        start = 1'b1; dividend = 8'd9; divisor = 8'd3;
        tick();
        start = 1'b0;
        repeat (5) tick();
        chk("ign.done_c9", done, 1);
        chk("ign.q_c9", quotient, 14);
        chk("ign.r_c9", remainder, 2);
        start = 1'b1; dividend = 8'd9; divisor = 8'd3;
        tick();
        chk("ign.busy_c10", busy, 0);
        chk("ign.q_c10", quotient, 14);
        chk("ign.r_c10", remainder, 2);
        tick();
        start = 1'b0;
        chk("ign.busy_c11", busy, 1);
        repeat (8) tick();
        chk("ign.done_c19", done, 1);
        chk("ign.q_9_3", quotient, 3);
        chk("ign.r_9_3", remainder, 0);
        tick();

        // Reset mid-operation aborts without a done pulse.
        start = 1'b1; dividend = 8'd100; divisor = 8'd7;
        tick();
        start = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort.busy", busy, 0);
        chk("abort.done", done, 0);
        chk("abort.quotient", quotient, 0);
        chk("abort.remainder", remainder, 0);
        chk("abort.dz", dz, 0);
        bad = 0;
        repeat (12) begin
            tick();
            if (done !== 1'b0 || busy !== 1'b0) bad++;
        end
        chk("abort.no_done", bad, 0);
        do_op(8'd77, 8'd10, "op77_10");

        for (int i = 0; i < 2000; i++) begin
            ra = 8'($urandom);
            rb = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom);
            do_op(ra, rb, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
